// File: rtl/temp_pkg.sv
// Shared types and constants for the temperature filter.
//   temp_t        : signed 8-bit temperature in degrees C
//   out_state_t   : output-side handshake state
//   TEMP_MIN_INIT / TEMP_MAX_INIT : empty-tracker values for min/max
package temp_pkg;

  typedef logic signed [7:0] temp_t;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } out_state_t;

  localparam temp_t TEMP_MIN_INIT = temp_t'(8'h7f);
  localparam temp_t TEMP_MAX_INIT = temp_t'(8'h80);

endpackage

// File: rtl/temp_alarm_hyst.sv
// Registered hysteresis comparator.
// DIR_HI=1: sets when value >= THRESH, clears when value < THRESH-HYST.
// DIR_HI=0: sets when value <= THRESH, clears when value > THRESH+HYST.
// Between the set and clear points the alarm holds.
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset
//   update_i       : evaluate value_i this cycle
//   value_i        : signed 8-bit value under test
//   alarm_o        : registered alarm
module temp_alarm_hyst #(
  parameter int THRESH = 85,
  parameter int HYST   = 3,
  parameter bit DIR_HI = 1'b1
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       update_i,
  input  logic [7:0] value_i,
  output logic       alarm_o
);

  // 10-bit signed compares so THRESH +/- HYST never wraps
  localparam logic signed [9:0] SET_TH = 10'(THRESH);
  localparam logic signed [9:0] CLR_TH = DIR_HI ? 10'(THRESH - HYST) : 10'(THRESH + HYST);

  logic signed [9:0] value_s;
  logic              alarm_q, alarm_d;

  assign value_s = {{2{value_i[7]}}, value_i};

  always_comb begin
    alarm_d = alarm_q;
    if (DIR_HI) begin
      if (value_s >= SET_TH)     alarm_d = 1'b1;
      else if (value_s < CLR_TH) alarm_d = 1'b0;
    end else begin
      if (value_s <= SET_TH)     alarm_d = 1'b1;
      else if (value_s > CLR_TH) alarm_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)       alarm_q <= 1'b0;
    else if (update_i) alarm_q <= alarm_d;
  end

  assign alarm_o = alarm_q;

endmodule

// File: rtl/temp_filter.sv
// Block-averaging filter for temperature-sensor conversions.
// Averages 2^AVG_LOG2 samples, presents the result on a valid/ready
// output, and tracks hysteresis alarms, raw min/max and a stale flag.
// Ports:
//   clk_i, reset_i     : clock, synchronous active-high reset
//   sample_valid_i     : 1-cycle strobe, new conversion present
//   sample_temp_i      : signed degrees C of the conversion
//   sample_count_i     : raw integration count of the conversion
//   clr_minmax_i       : clears the min/max trackers
//   out_ready_i        : consumer accepts avg_temp_o
//   out_valid_o        : avg_temp_o holds an unconsumed average
//   avg_temp_o         : signed block average (floor)
//   last_count_o       : sample_count of the latest sample
//   temp_min_o/_max_o  : signed running min/max of raw samples
//   alarm_hi_o/_lo_o   : hysteresis alarms on the average
//   overrun_o          : sticky, an unconsumed average was overwritten
//   stale_o            : no sample for TIMEOUT cycles
module temp_filter
  import temp_pkg::*;
#(
  parameter int AVG_LOG2 = 2,
  parameter int TH_HI    = 85,
  parameter int TH_LO    = -20,
  parameter int HYST     = 3,
  parameter int TIMEOUT  = 1000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       sample_valid_i,
  input  logic [7:0] sample_temp_i,
  input  logic [7:0] sample_count_i,
  input  logic       clr_minmax_i,
  input  logic       out_ready_i,
  output logic       out_valid_o,
  output logic [7:0] avg_temp_o,
  output logic [7:0] last_count_o,
  output logic [7:0] temp_min_o,
  output logic [7:0] temp_max_o,
  output logic       alarm_hi_o,
  output logic       alarm_lo_o,
  output logic       overrun_o,
  output logic       stale_o
);

  localparam int AW = 8 + AVG_LOG2;
  // keep the counter at least 1 bit wide; with AVG_LOG2=0 it stays at 0
  localparam int CW = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);
  localparam logic [15:0]   TO_VAL   = 16'(TIMEOUT);

  temp_t             sample_s;
  temp_t             avg_new;
  logic signed [AW-1:0] acc_q, acc_d, sum, sum_shr;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              complete;

  logic [7:0]        last_count_q, last_count_d;
  temp_t             min_q, min_d, max_q, max_d;
  logic [15:0]       timer_q, timer_d;
  logic              stale_q;

  out_state_t        state_q;
  logic              out_valid_q;
  temp_t             avg_q;
  logic              overrun_q;

  assign sample_s = temp_t'(sample_temp_i);
  assign sum      = acc_q + AW'(sample_s);
  assign sum_shr  = sum >>> AVG_LOG2;
  assign avg_new  = temp_t'(sum_shr[7:0]);
  assign complete = sample_valid_i && (cnt_q == CNT_LAST);

  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    last_count_d = last_count_q;
    if (sample_valid_i) begin
      acc_d        = complete ? '0 : sum;
      cnt_d        = complete ? '0 : cnt_q + CW'(1);
      last_count_d = sample_count_i;
    end
  end

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (clr_minmax_i) begin
      min_d = sample_valid_i ? sample_s : TEMP_MIN_INIT;
      max_d = sample_valid_i ? sample_s : TEMP_MAX_INIT;
    end else if (sample_valid_i) begin
      if (sample_s < min_q) min_d = sample_s;
      if (sample_s > max_q) max_d = sample_s;
    end
  end

  always_comb begin
    timer_d = timer_q;
    if (sample_valid_i)          timer_d = '0;
    else if (timer_q != TO_VAL)  timer_d = timer_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      last_count_q <= '0;
      min_q        <= TEMP_MIN_INIT;
      max_q        <= TEMP_MAX_INIT;
      timer_q      <= '0;
      stale_q      <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      last_count_q <= last_count_d;
      min_q        <= min_d;
      max_q        <= max_d;
      timer_q      <= timer_d;
      // compare the next timer value so a sample drops stale one cycle later
      stale_q      <= (timer_d == TO_VAL);
    end
  end

  // Output-side handshake: a completion always loads, ready only drains
  // when no new average arrives in the same cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_EMPTY;
      out_valid_q <= 1'b0;
      avg_q       <= '0;
      overrun_q   <= 1'b0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (complete) begin
            avg_q       <= avg_new;
            state_q     <= S_FULL;
            out_valid_q <= 1'b1;
          end
        end
        S_FULL: begin
          if (complete) begin
            avg_q <= avg_new;
            if (!out_ready_i) overrun_q <= 1'b1;
          end else if (out_ready_i) begin
            state_q     <= S_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_EMPTY;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  temp_alarm_hyst #(
    .THRESH (TH_HI),
    .HYST   (HYST),
    .DIR_HI (1'b1)
  ) u_alarm_hi (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .update_i (complete),
    .value_i  (avg_new),
    .alarm_o  (alarm_hi_o)
  );

  temp_alarm_hyst #(
    .THRESH (TH_LO),
    .HYST   (HYST),
    .DIR_HI (1'b0)
  ) u_alarm_lo (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .update_i (complete),
    .value_i  (avg_new),
    .alarm_o  (alarm_lo_o)
  );

  assign out_valid_o  = out_valid_q;
  assign avg_temp_o   = avg_q;
  assign last_count_o = last_count_q;
  assign temp_min_o   = min_q;
  assign temp_max_o   = max_q;
  assign overrun_o    = overrun_q;
  assign stale_o      = stale_q;

endmodule
